// File: rtl/bwt_enc_cyc_if.sv
`default_nettype none
// ============================================================================
// Module   : bwt_enc_cyc_if
// Purpose  : Start/done handshake plus input/output RAM bus of bwt_enc_cyc.
// Revision : 1.0
// ============================================================================
interface bwt_enc_cyc_if #(
  parameter int DW = 8,
  parameter int AW = 10
);
  logic          start;
  logic [AW-1:0] len_str;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] primary_idx;

  modport master (
    output start, len_str, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err, primary_idx
  );

  modport slave (
    input  start, len_str, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err, primary_idx
  );
endinterface
`default_nettype wire

// File: rtl/bwt_enc_cyc.sv
`default_nettype none
// ============================================================================
// Module   : bwt_enc_cyc
// Purpose  : Burrows-Wheeler encoder; bubble-sorts cyclic rotations, emits last column.
// Revision : 1.0
// ============================================================================
module bwt_enc_cyc #(
  parameter int DW      = 8,
  parameter int AW      = 10,
  parameter int MAX_LEN = 1024
) (
  input wire          clk,
  input wire          reset,
  bwt_enc_cyc_if.slave bus
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_OUTER, S_INNER, S_RD_A, S_RD_B,
    S_CMP, S_SWAP, S_EMIT_RD, S_EMIT_WR, S_DONE
  } state_t;

  state_t        state_q;
  logic [AW-1:0] len_q, i_q, j_q, t_q, n_q, a_q, b_q;
  logic [DW-1:0] sym_a_q;
  logic [AW-1:0] sa_q [MAX_LEN];
  logic          rd_en_q, wr_en_q, busy_q, done_q, err_q;
  logic [AW-1:0] rd_addr_q, wr_addr_q, pidx_q;

  logic          len_bad_d, more_outer_d, more_inner_d, more_t_d, more_n_d;
  logic [AW-1:0] j_p1_d, n_p1_d, t_p1_d;

  function automatic logic [IW-1:0] ix(input logic [AW-1:0] v);
    return v[IW-1:0];
  endfunction

  // (base + off) mod len with both operands below len: one conditional subtract
  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] base, input logic [AW-1:0] off,
                                         input logic [AW-1:0] len);
    logic [AW:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= {1'b0, len}) sum = sum - {1'b0, len};
    return sum[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] prev(input logic [AW-1:0] v, input logic [AW-1:0] len);
    return (v == '0) ? len - AW'(1) : v - AW'(1);
  endfunction

  assign len_bad_d    = (bus.len_str == '0) || ({1'b0, bus.len_str} > (AW+1)'(MAX_LEN));
  assign more_outer_d = ({1'b0, i_q} + (AW+1)'(1)) < {1'b0, len_q};
  assign more_inner_d = ({1'b0, j_q} + {1'b0, i_q} + (AW+1)'(1)) < {1'b0, len_q};
  assign more_t_d     = ({1'b0, t_q} + (AW+1)'(1)) < {1'b0, len_q};
  assign more_n_d     = ({1'b0, n_q} + (AW+1)'(1)) < {1'b0, len_q};
  assign j_p1_d       = j_q + AW'(1);
  assign n_p1_d       = n_q + AW'(1);
  assign t_p1_d       = t_q + AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      t_q       <= '0;
      n_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sym_a_q   <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      pidx_q    <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            err_q <= 1'b0;
            len_q <= bus.len_str;
            n_q   <= '0;
            if (len_bad_d) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_INIT;
            end
          end
        end
        S_INIT: begin
          sa_q[ix(n_q)] <= n_q;
          if (more_n_d) begin
            n_q <= n_p1_d;
          end else begin
            i_q     <= '0;
            state_q <= S_OUTER;
          end
        end
        S_OUTER: begin
          if (more_outer_d) begin
            j_q     <= '0;
            state_q <= S_INNER;
          end else begin
            n_q       <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= prev(sa_q[0], len_q);
            state_q   <= S_EMIT_RD;
          end
        end
        S_INNER: begin
          if (more_inner_d) begin
            a_q       <= sa_q[ix(j_q)];
            b_q       <= sa_q[ix(j_p1_d)];
            t_q       <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= sa_q[ix(j_q)];
            state_q   <= S_RD_A;
          end else begin
            i_q     <= i_q + AW'(1);
            state_q <= S_OUTER;
          end
        end
        S_RD_A: begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= wrap(b_q, t_q, len_q);
          state_q   <= S_RD_B;
        end
        S_RD_B: begin
          sym_a_q <= bus.rd_data;
          state_q <= S_CMP;
        end
        S_CMP: begin
          // Fully equal rotations fall through without a swap, keeping the sort stable
          if (bus.rd_data != sym_a_q) begin
            if (sym_a_q > bus.rd_data) begin
              state_q <= S_SWAP;
            end else begin
              j_q     <= j_p1_d;
              state_q <= S_INNER;
            end
          end else if (more_t_d) begin
            t_q       <= t_p1_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= wrap(a_q, t_p1_d, len_q);
            state_q   <= S_RD_A;
          end else begin
            j_q     <= j_p1_d;
            state_q <= S_INNER;
          end
        end
        S_SWAP: begin
          sa_q[ix(j_q)]    <= b_q;
          sa_q[ix(j_p1_d)] <= a_q;
          j_q              <= j_p1_d;
          state_q          <= S_INNER;
        end
        S_EMIT_RD: begin
          if (sa_q[ix(n_q)] == '0) pidx_q <= n_q;
          wr_en_q   <= 1'b1;
          wr_addr_q <= n_q;
          state_q   <= S_EMIT_WR;
        end
        S_EMIT_WR: begin
          if (more_n_d) begin
            n_q       <= n_p1_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= prev(sa_q[ix(n_p1_d)], len_q);
            state_q   <= S_EMIT_RD;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  // Read data of the emit read is forwarded in the write cycle; forced to 0 otherwise
  assign bus.wr_data     = wr_en_q ? bus.rd_data : '0;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.primary_idx = pidx_q;

endmodule
`default_nettype wire

// File: tb/tb_bwt_enc_cyc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bwt_enc_cyc
// Purpose  : Scoreboard bench for bwt_enc_cyc with hand-computed BWT vectors.
// Revision : 1.0
// ============================================================================
module tb_bwt_enc_cyc;

  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int MAX_LEN = 16;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { bit err; int pidx; } dn_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bwt_enc_cyc_if #(.DW(DW), .AW(AW)) bus ();

  bwt_enc_cyc #(.DW(DW), .AW(AW), .MAX_LEN(MAX_LEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] imem [2**AW];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= imem[bus.rd_addr];

  wr_t wq[$];
  dn_t dq[$];
  int  checks = 0, errors = 0;
  int  rd_cnt = 0, wr_cnt = 0, done_cnt = 0, oob_cnt = 0, both_cnt = 0;
  int  cur_len = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t w;
    dn_t d;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.rd_en) begin
          rd_cnt++;
          if (int'(bus.rd_addr) >= cur_len) oob_cnt++;
        end
        if (bus.rd_en && bus.wr_en) both_cnt++;
        if (bus.wr_en) begin
          wr_cnt++;
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=addr %0d data %0d required=no write",
                     bus.wr_addr, bus.wr_data);
          end else begin
            w = wq.pop_front();
            check($sformatf("wr_addr[%0d]", w.addr), bus.wr_addr, w.addr);
            check($sformatf("wr_data[%0d]", w.addr), bus.wr_data, w.data);
          end
        end
        if (bus.done) begin
          done_cnt++;
          if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            d = dq.pop_front();
            check("done_err", bus.err, d.err);
            if (!d.err) check("done_primary_idx", bus.primary_idx, d.pidx);
          end
        end
      end
    end
  endtask

  task automatic load(input string s);
    for (int k = 0; k < s.len(); k++) imem[k] = s[k];
  endtask

  task automatic run_job(input string tag, input string s, input int len, input string exp_s,
                         input int exp_p, input bit exp_err, input bit repulse);
    int rd0, wr0, dn0, cyc;
    load(s);
    cur_len  = len;
    oob_cnt  = 0;
    both_cnt = 0;
    if (!exp_err) for (int k = 0; k < len; k++) wq.push_back('{k, int'(exp_s[k])});
    dq.push_back('{exp_err, exp_p});
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.len_str = AW'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy_after_start"}, bus.busy, !exp_err);
    check({tag, "_err_after_start"}, bus.err, exp_err);
    cyc = 1;
    while (done_cnt == dn0 && cyc < 6000) begin
      if (repulse && cyc == 5) begin
        bus.start   = 1'b1;
        bus.len_str = AW'(3);
      end
      if (repulse && cyc == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done_seen"}, done_cnt - dn0, 1);
    if (exp_err) check({tag, "_err_latency_le3"}, cyc <= 3, 1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_count"}, done_cnt - dn0, 1);
    check({tag, "_write_count"}, wr_cnt - wr0, exp_err ? 0 : len);
    if (exp_err) check({tag, "_read_count"}, rd_cnt - rd0, 0);
    check({tag, "_rd_addr_out_of_range"}, oob_cnt, 0);
    check({tag, "_rd_wr_overlap"}, both_cnt, 0);
    check({tag, "_pending_writes"}, wq.size(), 0);
    check({tag, "_busy_idle"}, bus.busy, 0);
    check({tag, "_err_hold"}, bus.err, exp_err);
    if (!exp_err) check({tag, "_primary_idx_hold"}, bus.primary_idx, exp_p);
    wq.delete();
    dq.delete();
  endtask

  logic [5*1+3*AW+DW-1:0] outs;
  assign outs = {bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.err,
                 bus.primary_idx, bus.rd_addr, bus.wr_addr, bus.wr_data};

  initial begin
    int rd0, wr0, dn0;
    bus.start   = 1'b0;
    bus.len_str = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs, 0);
    reset = 1'b0;

    run_job("banana", "banana", 6, "nnbaaa", 3, 1'b0, 1'b0);
    run_job("single", "x", 1, "x", 0, 1'b0, 1'b0);
    run_job("aaaa", "aaaa", 4, "aaaa", 0, 1'b0, 1'b0);
    run_job("abab", "abab", 4, "bbaa", 0, 1'b0, 1'b0);
    run_job("len0", "", 0, "", 0, 1'b1, 1'b0);
    run_job("len_over", "", MAX_LEN + 1, "", 0, 1'b1, 1'b0);
    run_job("banana_clear_err_repulse", "banana", 6, "nnbaaa", 3, 1'b0, 1'b1);

    // Abort mid-sort: no expectations queued, so any write or done is flagged
    load("banana");
    cur_len = 6;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.len_str = AW'(6);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("busy_before_abort", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_reset_outputs", outs, 0);
    reset = 1'b0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_writes", wr_cnt - wr0, 0);
    check("abort_no_reads", rd_cnt - rd0, 0);
    check("abort_no_done", done_cnt - dn0, 0);
    check("abort_busy", bus.busy, 0);

    run_job("banana_after_reset", "banana", 6, "nnbaaa", 3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bwt_enc_cyc.md
Name: bwt_enc_cyc

Overview:
Parametrised Burrows-Wheeler encoder, the successor to the team's first BWT block. It sorts all cyclic rotations of a string held in external RAM and writes the BWT last column to an output RAM. It also reports the primary index needed by the inverse transform. It adds a start/busy/done handshake, generic symbol and address widths, bounded cyclic comparison and length error detection.

Parameters:
DW, 8, symbol width in bits
AW, 10, address width for input RAM, output RAM and length
MAX_LEN, 1024, depth of the internal rotation index array; must be <= 2**AW

Ports:
clk  in  1  clock, all activity on rising edge
reset  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
len_str  in  AW  string length; sampled on accepted start
rd_en  out  1  input RAM read enable
rd_addr  out  AW  input RAM address
rd_data  in  DW  input RAM data, valid on the cycle after rd_en
wr_en  out  1  output RAM write strobe, one cycle per symbol
wr_addr  out  AW  output RAM address
wr_data  out  DW  BWT symbol
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at job end (success or error)
err  out  1  held high from an error done until the next accepted start
primary_idx  out  AW  sorted row holding rotation 0; valid from done until the next accepted start

Behaviour:
- Reset, synchronous and active-high, takes effect on the clock edge:
  - state=IDLE
  - all outputs 0: rd_en, wr_en, busy, done, err, primary_idx, rd_addr, wr_addr, wr_data
  - reset mid-job aborts with no further RAM writes.
- Start handling:
  - start while busy is ignored.
  - On accept, latch len_str as L and clear err.
  - L==0 or L>MAX_LEN: go to DONE with err=1, no RAM access.
- FSM states: IDLE, INIT, OUTER, INNER, RD_A, RD_B, CMP, SWAP, EMIT_RD, EMIT_WR, DONE.
- INIT: write sa[n]=n for n=0..L-1, one entry per cycle (L cycles), then go to OUTER with i=0.
- Sort is a stable bubble sort over the rotation index array sa[].
  - OUTER: if i<L-1, set j=0 and go to INNER; otherwise go to EMIT_RD with n=0.
  - INNER: if j<L-1-i, set a=sa[j], b=sa[j+1], t=0 and go to RD_A; otherwise i++ and go to OUTER.
- Comparison of rotations a and b:
  - RD_A reads S[(a+t) mod L]; RD_B latches it as A and reads S[(b+t) mod L]; CMP latches it as B.
  - Modulo is done by conditional subtract (a+t < 2L). No multiplier or divider.
  - In CMP:
    - A!=B: go to SWAP if A>B (unsigned), else j++ and go to INNER.
    - A==B and t<L-1: t++ and go to RD_A.
    - A==B and t==L-1: rotations are identical, no swap, j++ and go to INNER. This keeps the sort stable.
  - Reads never address outside 0..L-1.
- SWAP: exchange sa[j] and sa[j+1], j++, go to INNER.
- Emit, for n=0..L-1:
  - EMIT_RD: rd_addr = (sa[n]==0) ? L-1 : sa[n]-1, rd_en=1. If sa[n]==0, primary_idx=n.
  - EMIT_WR: wr_en=1, wr_addr=n, wr_data=rd_data, n++.
  - Exactly L writes, in ascending wr_addr order.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- rd_en and wr_en are never high in the same cycle. rd_en is 0 in IDLE, INIT, DONE.
- Input RAM must not change while busy; output is undefined if it does.
- Worst-case latency is O(L^3) cycles. No throughput requirement.

Test Plan:
- "banana", L=6, start pulse -> six writes to addr 0..5 with data "nnbaaa", primary_idx=3, done pulses once, err=0.
- L=1, "x" -> one write of 'x' at addr 0, primary_idx=0, done pulses once.
- "aaaa", L=4 (all rotations equal, full-length compare) -> "aaaa", primary_idx=0, no swaps. Also check rd_addr stays <4 throughout.
- Periodic "abab", L=4 -> "bbaa", primary_idx=0 (stable order 0,2,1,3).
- Error cases:
  - L=0 -> done within 3 cycles, err=1, no rd_en or wr_en.
  - L=MAX_LEN+1 -> same response.
  - Then a valid start clears err.
- Control edge cases:
  - start re-pulsed while busy -> ignored, result unchanged.
  - reset asserted mid-sort -> next edge gives all outputs 0 and no writes.
  - Re-run "banana" after reset -> correct result.
